handshake_slice: RTL and testbench

//  Valid/ready register slice: a pipelined datapath stage that adds backpressure.

---
 rtl/handshake_slice.sv | 183 ++++++++++++++++++
 tb/tb_handshake_slice.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_slice.sv
// Purpose     : valid/ready register slice; num_stages cascaded skid stages that cut both
//               the forward valid/data path and the backward ready path.
// Latency     : a word accepted at edge N into an empty slice shows out_valid after edge
//               N+num_stages-1 and can leave at edge N+num_stages; 1 word/clk sustained.
// Backpressure: holds up to 2*num_stages words; in_ready is registered per stage and
//               drops only when the first stage's skid register is occupied.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low (0 = in reset)
//   in_valid / in_ready / in_data     upstream side
//   out_valid / out_ready / out_data  downstream side
//   occupancy  words held in the slice (only with HANDSHAKE_SLICE_OCCUPANCY_EN defined)
//
// Optional feature macro: HANDSHAKE_SLICE_OCCUPANCY_EN
module handshake_slice #(
  parameter int                  num_bits    = 8,
  parameter int                  num_stages  = 1,
  parameter logic [num_bits-1:0] initial_val = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [num_bits-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [num_bits-1:0] out_data
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
  ,
  output logic [$clog2(2*num_stages+1)-1:0] occupancy
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Holds in_ready low for the first edge after reset release so nothing is
  // accepted while the slice is still coming out of reset.
  logic ready_en;

  // Per-stage handshake wiring: stage k's out side drives stage k+1's in side.
  logic [num_stages-1:0] stg_in_vld;
  logic [num_stages-1:0] stg_out_rdy;
  logic [num_stages-1:0] stg_rdy;
  logic [num_stages-1:0] main_vld;
  logic [num_bits-1:0]   stg_in_dat [num_stages];
  logic [num_bits-1:0]   main_dat   [num_stages];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign in_ready  = stg_rdy[0] && ready_en;
  assign out_valid = main_vld[num_stages-1];
  assign out_data  = main_dat[num_stages-1];

  for (genvar k = 0; k < num_stages; k++) begin : g_stage
    state_t              state_q;
    state_t              state_d;
    logic [num_bits-1:0] main_dat_q;
    logic [num_bits-1:0] skid_dat_q;
    logic                in_xfer;
    logic                out_xfer;
    logic                load_main_in;
    logic                load_main_skid;
    logic                load_skid;

    if (k == 0) begin : g_head
      // ready_en gating keeps the first stage consistent with in_ready.
      assign stg_in_vld[k] = in_valid && ready_en;
      assign stg_in_dat[k] = in_data;
    end else begin : g_link
      assign stg_in_vld[k] = main_vld[k-1];
      assign stg_in_dat[k] = main_dat[k-1];
    end

    if (k == num_stages - 1) begin : g_tail
      assign stg_out_rdy[k] = out_ready;
    end else begin : g_mid
      assign stg_out_rdy[k] = stg_rdy[k+1];
    end

    // Ready comes only from this stage's own state register, so no ready
    // path spans more than one stage.
    assign stg_rdy[k]  = (state_q != FULL);
    assign main_vld[k] = (state_q != EMPTY);
    assign main_dat[k] = main_dat_q;

    assign in_xfer  = stg_in_vld[k] && stg_rdy[k];
    assign out_xfer = main_vld[k] && stg_out_rdy[k];

    always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            // Pass-through at full rate: replace the departing word, no bubble.
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            // Downstream stalled this cycle; park the new word in the skid reg.
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Data regs keep stale contents when empty; only the valids qualify them.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        main_dat_q <= initial_val;
        skid_dat_q <= initial_val;
      end else begin
        if (load_main_in) begin
          main_dat_q <= stg_in_dat[k];
        end else if (load_main_skid) begin
          main_dat_q <= skid_dat_q;
        end
        if (load_skid) begin
          skid_dat_q <= stg_in_dat[k];
        end
      end
    end
  end

`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
  localparam int occ_w = $clog2(2*num_stages+1);

  logic [occ_w-1:0] occ_q;
  logic             occ_in_xfer;
  logic             occ_out_xfer;

  assign occ_in_xfer  = in_valid && in_ready;
  assign occ_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else if (occ_in_xfer && !occ_out_xfer) begin
      occ_q <= occ_q + occ_w'(1);
    end else if (!occ_in_xfer && occ_out_xfer) begin
      occ_q <= occ_q - occ_w'(1);
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_handshake_slice.sv
// Directed bench for handshake_slice with num_stages=2, num_bits=8.
// A queue scoreboard follows every transfer; expected values are hand-derived.
module tb_handshake_slice;

  localparam int         NB = 8;
  localparam int         NS = 2;
  localparam logic [7:0] IV = 8'h3C;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [NB-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [NB-1:0] out_data;
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
  logic [2:0]   occupancy;
`endif

  always #5 clk = ~clk;

  handshake_slice #(
    .num_bits   (NB),
    .num_stages (NS),
    .initial_val(IV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  int         n_in, n_out, edge_no, first_out, last_out, viol, base;
  bit         occ_rule_on;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log transfers against the model, then step to 1 time unit past the edge.
  task automatic cycle();
    logic [7:0] w;
    if (reset) begin
      if (occ_rule_on && sb.size() < 2*NS-1 && in_ready !== 1'b1) viol++;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          w = sb.pop_front();
          chk("out_order", 32'(out_data), 32'(w));
        end
        n_out++;
        if (first_out < 0) first_out = edge_no + 1;
        last_out = edge_no + 1;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        n_in++;
      end
    end
    @(posedge clk);
    #1;
    edge_no++;
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
    if (reset) chk("occupancy", 32'(occupancy), 32'(sb.size()));
`endif
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < budget && sb.size() != 0; t++) cycle();
    chk("drain_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    n_in = 0; n_out = 0; edge_no = 0; first_out = -1; last_out = 0; viol = 0;
    occ_rule_on = 1'b0;

    // Reset state and release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 32'(IV));
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
    chk("rst_occupancy", 32'(occupancy), 0);
`endif
    #4 reset = 1'b1;
    chk("rel_in_ready_before_edge", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", 32'(in_ready), 1);

    // Back-to-back stream 0x01..0x10 with out_ready held high
    out_ready = 1'b1; n_in = 0; n_out = 0; first_out = -1; base = edge_no;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      cycle();
      if (i == 1) chk("lat_after_accept_edge", 32'(out_valid), 0);
      if (i == 2) chk("lat_after_next_edge", 32'(out_valid), 1);
    end
    drain(10);
    chk("stream_in_count", 32'(n_in), 16);
    chk("stream_out_count", 32'(n_out), 16);
    chk("stream_first_out_edge", 32'(first_out - base), 3);
    chk("stream_no_bubbles", 32'(last_out - first_out), 15);

    // Asynchronous reset mid-stream, no clock edge in between
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'h41; cycle();
    in_data = 8'h42; cycle();
    chk("pre_reset_out_valid", 32'(out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    chk("async_rst_out_data", 32'(out_data), 32'(IV));
    sb.delete();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    chk("async_rel_in_ready_before_edge", 32'(in_ready), 0);
    @(posedge clk); #1; edge_no++;
    chk("async_rel_in_ready_after_edge", 32'(in_ready), 1);
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
    chk("async_rel_occupancy", 32'(occupancy), 0);
`endif

    // Fill with downstream stalled: capacity is exactly 4
    out_ready = 1'b0; in_valid = 1'b1; n_in = 0;
    for (int k = 0; k < 8; k++) begin
      in_data = 8'h20 + 8'(k);
      cycle();
    end
    chk("fill_accepted", 32'(n_in), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_model_count", 32'(sb.size()), 4);
    chk("fill_out_data_oldest", 32'(out_data), 32'h20);
    n_out = 0;
    drain(20);
    chk("fill_drained", 32'(n_out), 4);
    chk("fill_in_ready_back", 32'(in_ready), 1);

    // Stall with a word presented; toggle in_data underneath
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h55; cycle();
    in_data = 8'h66; cycle();
    for (int i = 0; i < 10; i++) begin
      in_data = (i % 2 == 0) ? 8'hAA : 8'h0F;
      cycle();
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_data", 32'(out_data), 32'h55);
    end
    drain(20);

    // Random traffic, 1000 words
    n_in = 0; n_out = 0; viol = 0; occ_rule_on = 1'b1;
    for (int t = 0; t < 20000 && n_in < 1000; t++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain(20);
    occ_rule_on = 1'b0;
    chk("rand_in_count", 32'(n_in), 1000);
    chk("rand_out_count", 32'(n_out), 1000);
    chk("rand_ready_rule_violations", 32'(viol), 0);

    // Reset while holding 3 words, then a single 0xA5
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h70 + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    chk("held_model_count", 32'(sb.size()), 3);
    chk("held_out_valid", 32'(out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("held_rst_out_valid", 32'(out_valid), 0);
    chk("held_rst_in_ready", 32'(in_ready), 0);
    sb.delete();
    #2 reset = 1'b1;
    @(posedge clk); #1; edge_no++;
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
    chk("a5_occ_start", 32'(occupancy), 0);
`endif
    n_out = 0;
    in_valid = 1'b1; in_data = 8'hA5;
    cycle();
    in_valid = 1'b0; in_data = 8'h00;
`ifdef HANDSHAKE_SLICE_OCCUPANCY_EN
    chk("a5_occ_one", 32'(occupancy), 1);
`endif
    cycle();
    chk("a5_out_valid", 32'(out_valid), 1);
    chk("a5_out_data", 32'(out_data), 32'hA5);
    drain(10);
    chk("a5_only_word", 32'(n_out), 1);
    cycle();
    chk("a5_after_out_valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
